// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports plus the shared data-memory port.
// The arbiter connects through the slave modport; the requesters/memory side uses master.
interface data_mem_arbiter_if;
  logic        r0_req;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_we;
  logic [3:0]  r0_sign_mask;
  logic        r0_ack;
  logic [31:0] r0_rdata;
  logic        r0_err;

  logic        r1_req;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_we;
  logic [3:0]  r1_sign_mask;
  logic        r1_ack;
  logic [31:0] r1_rdata;
  logic        r1_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;
  logic        bus_err;

  modport slave (
    input  r0_req, r0_addr, r0_wdata, r0_we, r0_sign_mask,
    output r0_ack, r0_rdata, r0_err,
    input  r1_req, r1_addr, r1_wdata, r1_we, r1_sign_mask,
    output r1_ack, r1_rdata, r1_err,
    output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
    input  mem_read_data, mem_clk_stall,
    output bus_err
  );

  modport master (
    output r0_req, r0_addr, r0_wdata, r0_we, r0_sign_mask,
    input  r0_ack, r0_rdata, r0_err,
    output r1_req, r1_addr, r1_wdata, r1_we, r1_sign_mask,
    input  r1_ack, r1_rdata, r1_err,
    input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
    output mem_read_data, mem_clk_stall,
    input  bus_err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the clk_stall-handshaked data memory between two masters,
// with single-cycle strobes, per-port ack/rdata and a watchdog on the memory's busy response.
module data_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             cur_we;
  logic [CNT_W-1:0] wait_cnt;

  logic             any_req;
  logic             pick1;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_we;
  logic [3:0]       sel_mask;

  // On a tie the port that did not win last time is chosen.
  assign any_req   = bus.r0_req | bus.r1_req;
  assign pick1     = bus.r1_req & (~bus.r0_req | ~last_grant);
  assign sel_addr  = pick1 ? bus.r1_addr      : bus.r0_addr;
  assign sel_wdata = pick1 ? bus.r1_wdata     : bus.r0_wdata;
  assign sel_we    = pick1 ? bus.r1_we        : bus.r0_we;
  assign sel_mask  = pick1 ? bus.r1_sign_mask : bus.r0_sign_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= 1'b1;
      grant              <= 1'b0;
      cur_we             <= 1'b0;
      wait_cnt           <= '0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      bus.mem_sign_mask  <= '0;
      bus.mem_memread    <= 1'b0;
      bus.mem_memwrite   <= 1'b0;
      bus.r0_ack         <= 1'b0;
      bus.r1_ack         <= 1'b0;
      bus.r0_err         <= 1'b0;
      bus.r1_err         <= 1'b0;
      bus.r0_rdata       <= '0;
      bus.r1_rdata       <= '0;
      bus.bus_err        <= 1'b0;
    end else begin
      bus.mem_memread  <= 1'b0;
      bus.mem_memwrite <= 1'b0;
      bus.r0_ack       <= 1'b0;
      bus.r1_ack       <= 1'b0;
      bus.r0_err       <= 1'b0;
      bus.r1_err       <= 1'b0;

      case (state)
        // Strobes are registered here so they are high during the ISSUE cycle only.
        IDLE: begin
          if (any_req && !bus.mem_clk_stall) begin
            grant              <= pick1;
            last_grant         <= pick1;
            cur_we             <= sel_we;
            bus.mem_addr       <= sel_addr;
            bus.mem_write_data <= sel_wdata;
            bus.mem_sign_mask  <= sel_mask;
            bus.mem_memread    <= ~sel_we;
            bus.mem_memwrite   <= sel_we;
            state              <= ISSUE;
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (bus.mem_clk_stall) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            bus.bus_err <= 1'b1;
            if (grant) begin
              bus.r1_rdata <= '0;
              bus.r1_err   <= 1'b1;
              bus.r1_ack   <= 1'b1;
            end else begin
              bus.r0_rdata <= '0;
              bus.r0_err   <= 1'b1;
              bus.r0_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!bus.mem_clk_stall) begin
            if (grant) begin
              if (!cur_we) bus.r1_rdata <= bus.mem_read_data;
              bus.r1_ack <= 1'b1;
            end else begin
              if (!cur_we) bus.r0_rdata <= bus.mem_read_data;
              bus.r0_ack <= 1'b1;
            end
            state <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a stalling memory model plus a queue of expected responses
// that is consumed whenever a requester sees its ack.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  data_mem_arbiter_if bus();

  data_mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] pend_addr    = '0;
  logic [31:0] mem_rdata    = '0;
  logic        mem_stall    = 1'b0;
  logic [31:0] last_wr_data = '0;
  int          stall_left   = 0;
  int          stall_len    = 2;
  logic        no_respond   = 1'b0;

  assign bus.mem_clk_stall = mem_stall;
  assign bus.mem_read_data = mem_rdata;

  // Memory: busy for stall_len cycles after a strobe, data valid when busy drops.
  always @(posedge clk) begin
    if ((bus.mem_memread || bus.mem_memwrite) && !no_respond) begin
      mem_stall  <= 1'b1;
      stall_left <= stall_len - 1;
      pend_addr  <= bus.mem_addr;
      if (bus.mem_memwrite) last_wr_data <= bus.mem_write_data;
    end else if (mem_stall) begin
      if (stall_left == 0) begin
        mem_stall <= 1'b0;
        mem_rdata <= (mem_model.exists(pend_addr) != 0) ? mem_model[pend_addr] : 32'h0;
      end else begin
        stall_left <= stall_left - 1;
      end
    end
  end

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 8;
    if (bus.mem_memread !== 1'b0 || bus.mem_memwrite !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_strobes got=%b%b want=00", bus.mem_memread, bus.mem_memwrite);
    end
    if (bus.r0_ack !== 1'b0 || bus.r1_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_acks got=%b%b want=00", bus.r0_ack, bus.r1_ack);
    end
    if (bus.r0_err !== 1'b0 || bus.r1_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_errs got=%b%b want=00", bus.r0_err, bus.r1_err);
    end
    if (bus.bus_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_bus_err got=%b want=0", bus.bus_err);
    end
    if (bus.mem_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_mem_addr got=%h want=0", bus.mem_addr);
    end
    if (bus.mem_write_data !== 32'h0 || bus.mem_sign_mask !== 4'h0) begin
      bad++; $display("[TB] FAIL reset_mem_wdata_mask got=%h/%h want=0/0", bus.mem_write_data, bus.mem_sign_mask);
    end
    if (bus.r0_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_r0_rdata got=%h want=0", bus.r0_rdata);
    end
    if (bus.r1_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_r1_rdata got=%h want=0", bus.r1_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    exp_t        e;
    int          ack_cycle   = -1;
    int          rd_first    = -1;
    int          rd_count    = 0;
    int          r1_acks     = 0;
    logic [31:0] strobe_addr = '0;
    repeat (2) @(negedge clk);
    e.port = 0; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
    exp_q.push_back(e);
    bus.r0_addr = 32'h1004; bus.r0_wdata = 32'h0; bus.r0_we = 1'b0;
    bus.r0_sign_mask = 4'b0010; bus.r0_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.mem_memread) begin
        rd_count++;
        if (rd_first < 0) begin rd_first = c; strobe_addr = bus.mem_addr; end
      end
      if (bus.r1_ack) r1_acks++;
      if (bus.r0_ack) begin
        ack_cycle = c;
        bus.r0_req = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL load_unexpected_ack got=ack want=none");
        end else begin
          e = exp_q.pop_front();
          total += 2;
          if (bus.r0_rdata !== e.rdata) begin
            bad++; $display("[TB] FAIL load_rdata got=%h want=%h", bus.r0_rdata, e.rdata);
          end
          if (bus.r0_err !== e.err) begin
            bad++; $display("[TB] FAIL load_err got=%b want=%b", bus.r0_err, e.err);
          end
        end
      end
    end
    bus.r0_req = 1'b0;
    total += 5;
    if (rd_first != 1) begin bad++; $display("[TB] FAIL load_strobe_cycle got=%0d want=1", rd_first); end
    if (rd_count != 1) begin bad++; $display("[TB] FAIL load_strobe_count got=%0d want=1", rd_count); end
    if (strobe_addr !== 32'h1004) begin bad++; $display("[TB] FAIL load_addr got=%h want=00001004", strobe_addr); end
    if (ack_cycle != 5) begin bad++; $display("[TB] FAIL load_ack_cycle got=%0d want=5", ack_cycle); end
    if (r1_acks != 0) begin bad++; $display("[TB] FAIL load_r1_ack got=%0d want=0", r1_acks); end
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   n_acks = 0;
    int   got_port;
    int   ack_at [3];
    ack_at = '{-100, -100, -100};
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      e.port  = i % 2;
      e.rdata = (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678;
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    bus.r0_addr = 32'h1004; bus.r0_we = 1'b0; bus.r0_sign_mask = 4'b0010; bus.r0_req = 1'b1;
    bus.r1_addr = 32'h1008; bus.r1_wdata = 32'h0; bus.r1_we = 1'b0;
    bus.r1_sign_mask = 4'b0010; bus.r1_req = 1'b1;
    for (int c = 1; c <= 40 && n_acks < 3; c++) begin
      @(negedge clk);
      if (bus.r0_ack || bus.r1_ack) begin
        got_port = bus.r1_ack ? 1 : 0;
        ack_at[n_acks] = c;
        n_acks++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL rr_unexpected_ack got=port%0d want=none", got_port);
        end else begin
          e = exp_q.pop_front();
          total += 2;
          if (got_port != e.port) begin
            bad++; $display("[TB] FAIL rr_port got=%0d want=%0d", got_port, e.port);
          end
          if ((got_port == 1 ? bus.r1_rdata : bus.r0_rdata) !== e.rdata) begin
            bad++; $display("[TB] FAIL rr_rdata got=%h want=%h",
                            (got_port == 1 ? bus.r1_rdata : bus.r0_rdata), e.rdata);
          end
        end
      end
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    total += 4;
    if (n_acks != 3) begin bad++; $display("[TB] FAIL rr_ack_count got=%0d want=3", n_acks); end
    if (ack_at[0] != 5) begin bad++; $display("[TB] FAIL rr_first_ack got=%0d want=5", ack_at[0]); end
    if (ack_at[1] - ack_at[0] != 6) begin
      bad++; $display("[TB] FAIL rr_gap1 got=%0d want=6", ack_at[1] - ack_at[0]);
    end
    if (ack_at[2] - ack_at[1] != 6) begin
      bad++; $display("[TB] FAIL rr_gap2 got=%0d want=6", ack_at[2] - ack_at[1]);
    end
    exp_q.delete();
  endtask

  task automatic test_store();
    exp_t        e;
    int          ack_cycle = -1;
    int          wr_first  = -1;
    int          wr_count  = 0;
    int          rd_count  = 0;
    logic [31:0] wr_data   = '0;
    logic [31:0] wr_addr   = '0;
    logic [3:0]  wr_mask   = '0;
    repeat (2) @(negedge clk);
    // Port 1 last loaded 0x12345678 and a store must leave that in place.
    e.port = 1; e.rdata = 32'h12345678; e.err = 1'b0;
    exp_q.push_back(e);
    bus.r1_addr = 32'h2000; bus.r1_wdata = 32'h000000A5; bus.r1_we = 1'b1;
    bus.r1_sign_mask = 4'b0100; bus.r1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.mem_memread) rd_count++;
      if (bus.mem_memwrite) begin
        wr_count++;
        if (wr_first < 0) begin
          wr_first = c; wr_data = bus.mem_write_data; wr_addr = bus.mem_addr; wr_mask = bus.mem_sign_mask;
        end
      end
      if (bus.r1_ack) begin
        ack_cycle = c;
        bus.r1_req = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL store_unexpected_ack got=ack want=none");
        end else begin
          e = exp_q.pop_front();
          total += 2;
          if (bus.r1_rdata !== e.rdata) begin
            bad++; $display("[TB] FAIL store_rdata got=%h want=%h", bus.r1_rdata, e.rdata);
          end
          if (bus.r1_err !== e.err) begin
            bad++; $display("[TB] FAIL store_err got=%b want=%b", bus.r1_err, e.err);
          end
        end
      end
    end
    bus.r1_req = 1'b0;
    total += 8;
    if (wr_first != 1) begin bad++; $display("[TB] FAIL store_strobe_cycle got=%0d want=1", wr_first); end
    if (wr_count != 1) begin bad++; $display("[TB] FAIL store_strobe_count got=%0d want=1", wr_count); end
    if (rd_count != 0) begin bad++; $display("[TB] FAIL store_memread got=%0d want=0", rd_count); end
    if (wr_data !== 32'hA5) begin bad++; $display("[TB] FAIL store_wdata got=%h want=000000a5", wr_data); end
    if (wr_addr !== 32'h2000 || wr_mask !== 4'b0100) begin
      bad++; $display("[TB] FAIL store_addr_mask got=%h/%b want=00002000/0100", wr_addr, wr_mask);
    end
    if (ack_cycle != 5) begin bad++; $display("[TB] FAIL store_ack_cycle got=%0d want=5", ack_cycle); end
    if (last_wr_data !== 32'hA5) begin bad++; $display("[TB] FAIL store_mem_data got=%h want=000000a5", last_wr_data); end
    if (bus.mem_addr !== 32'h2000) begin bad++; $display("[TB] FAIL store_addr_hold got=%h want=00002000", bus.mem_addr); end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   ack_cycle = -1;
    int   r1_acks   = 0;
    repeat (2) @(negedge clk);
    no_respond = 1'b1;
    e.port = 0; e.rdata = 32'h0; e.err = 1'b1;
    exp_q.push_back(e);
    bus.r0_addr = 32'h1004; bus.r0_we = 1'b0; bus.r0_sign_mask = 4'b0010; bus.r0_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.r1_ack) r1_acks++;
      if (bus.r0_ack) begin
        ack_cycle = c;
        bus.r0_req = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL timeout_unexpected_ack got=ack want=none");
        end else begin
          e = exp_q.pop_front();
          total += 2;
          if (bus.r0_rdata !== e.rdata) begin
            bad++; $display("[TB] FAIL timeout_rdata got=%h want=%h", bus.r0_rdata, e.rdata);
          end
          if (bus.r0_err !== e.err) begin
            bad++; $display("[TB] FAIL timeout_err got=%b want=%b", bus.r0_err, e.err);
          end
        end
      end
    end
    bus.r0_req = 1'b0;
    total += 4;
    if (ack_cycle != 18) begin bad++; $display("[TB] FAIL timeout_ack_cycle got=%0d want=18", ack_cycle); end
    if (r1_acks != 0) begin bad++; $display("[TB] FAIL timeout_r1_ack got=%0d want=0", r1_acks); end
    if (bus.bus_err !== 1'b1) begin bad++; $display("[TB] FAIL timeout_bus_err_sticky got=%b want=1", bus.bus_err); end
    no_respond = 1'b0;
    apply_reset(1);
    if (bus.bus_err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_bus_err_clear got=%b want=0", bus.bus_err); end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   early_strobe = 0;
    int   strobe_cyc   = -1;
    int   ack_cycle    = -1;
    int   n_acks       = 0;
    repeat (2) @(negedge clk);
    stall_len = 8;
    bus.r0_addr = 32'h1004; bus.r0_we = 1'b0; bus.r0_sign_mask = 4'b0010; bus.r0_req = 1'b1;
    repeat (3) @(negedge clk);
    // Arbiter sits in WAIT_DONE here with the memory still busy.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_len = 2;
    total += 2;
    if (bus.r0_ack !== 1'b0 || bus.mem_memread !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_after_reset got=ack%b rd%b want=ack0 rd0", bus.r0_ack, bus.mem_memread);
    end
    if (mem_stall !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_mem_busy got=%b want=1", mem_stall);
    end
    e.port = 0; e.rdata = 32'h12345678; e.err = 1'b0;
    exp_q.push_back(e);
    bus.r0_addr = 32'h1008;
    for (int c = 5; c <= 25; c++) begin
      @(negedge clk);
      if (bus.mem_memread || bus.mem_memwrite) begin
        if (mem_stall) early_strobe++;
        if (strobe_cyc < 0) strobe_cyc = c;
      end
      if (bus.r0_ack) begin
        n_acks++;
        ack_cycle = c;
        bus.r0_req = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL abort_unexpected_ack got=ack want=none");
        end else begin
          e = exp_q.pop_front();
          total++;
          if (bus.r0_rdata !== e.rdata) begin
            bad++; $display("[TB] FAIL abort_rdata got=%h want=%h", bus.r0_rdata, e.rdata);
          end
        end
      end
    end
    bus.r0_req = 1'b0;
    total += 4;
    if (early_strobe != 0) begin bad++; $display("[TB] FAIL abort_strobe_while_busy got=%0d want=0", early_strobe); end
    if (strobe_cyc != 11) begin bad++; $display("[TB] FAIL abort_strobe_cycle got=%0d want=11", strobe_cyc); end
    if (ack_cycle != 15) begin bad++; $display("[TB] FAIL abort_ack_cycle got=%0d want=15", ack_cycle); end
    if (n_acks != 1) begin bad++; $display("[TB] FAIL abort_ack_count got=%0d want=1", n_acks); end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.r0_req = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_we = 1'b0; bus.r0_sign_mask = '0;
    bus.r1_req = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_we = 1'b0; bus.r1_sign_mask = '0;
    mem_model[32'h1004] = 32'hDEADBEEF;
    mem_model[32'h1008] = 32'h12345678;
    $display("[TB] starting data_mem_arbiter bench");
    test_reset();
    test_single_load();
    test_round_robin();
    test_store();
    test_timeout();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single data-memory port (the `clk_stall`-handshaked load/store memory with LED register at 0x2000) between the processor load/store unit (port 0) and a second bus master such as a DMA or debug unit (port 1). It serialises the requests with round-robin priority and issues each one as a single-cycle strobe. It tracks the memory's `clk_stall` busy window, returns read data and a one-cycle acknowledge to the winning requester, and flags a watchdog timeout if the memory never responds.

## Interface
- `TIMEOUT_CYCLES`, 15: cycles allowed in WAIT_ACK for `mem_clk_stall` to rise before the error path is taken.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rN_req`  in  1  (N=0,1) request; held high with fields stable until `rN_ack`.
- `rN_addr`  in  32  byte address.
- `rN_wdata`  in  32  store data.
- `rN_we`  in  1  1 = store, 0 = load.
- `rN_sign_mask`  in  4  width/sign code, forwarded unchanged.
- `rN_ack`  out  1  one-cycle completion pulse.
- `rN_rdata`  out  32  load data; valid while `rN_ack`=1, held afterwards.
- `rN_err`  out  1  pulses with `rN_ack` on timeout.
- `mem_addr`, `mem_write_data`  out  32  to the memory.
- `mem_memread`, `mem_memwrite`  out  1  single-cycle strobes.
- `mem_sign_mask`  out  4  to the memory.
- `mem_read_data`  in  32  from the memory.
- `mem_clk_stall`  in  1  memory busy.
- `bus_err`  out  1  sticky timeout flag; cleared only by `reset`.

## Operation
- All outputs are registered. Reset values: every strobe, ack and err output is 0, all data and address outputs are 0, `bus_err`=0, state is IDLE, and the last-grant pointer is 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: when any `rN_req`=1 and `mem_clk_stall`=0, pick the winner and latch its addr, wdata, we and sign_mask into the `mem_*` outputs. Go to ISSUE.
  - Only one requester: it wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer updates on every grant.
  - A request is never accepted while `mem_clk_stall`=1. This covers a memory still busy after an arbiter reset.
- ISSUE: for exactly this one cycle, `mem_memread`=~we and `mem_memwrite`=we. Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - `mem_clk_stall`=1: go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`: set `bus_err`, set the winner's `rN_rdata`=0 and `rN_err`=1, and go to RESP.
- WAIT_DONE: when `mem_clk_stall`=0, capture `mem_read_data` into the winner's `rN_rdata` and go to RESP. For writes, `rN_rdata` is left unchanged.
- RESP: the winner's `rN_ack`=1 for this cycle only. All requests are ignored here, so the requester has this cycle to drop `req`. Go to IDLE.
- The `mem_*` address, data and mask outputs hold their values after the transaction. Only the strobes return to 0.
- A requester dropping `req` before its ack is a protocol violation. Once the arbiter has granted, it completes the transaction anyway.

## Timing
- `req` high in cycle t with the arbiter idle and the memory idle:
  - t+1: strobe high.
  - t+2 and t+3: `mem_clk_stall`=1.
  - t+4: `mem_clk_stall`=0 and read data valid.
  - t+5: `rN_ack` high.
  - t+6: IDLE again, next grant possible.
- Latency is 5 cycles request-to-ack for both loads and stores. Throughput is one transaction per 6 cycles.
- Back-to-back on both ports: grants alternate 0,1,0,1. Neither port waits more than one transaction.
- Timeout path: ack occurs `TIMEOUT_CYCLES`+3 cycles after `req`.
- Reset asserted in any state: on the next edge the state is IDLE, strobes and acks are 0, and no ack is produced for the aborted transaction. The next issue waits for `mem_clk_stall`=0.

## Test plan
- Port 0 loads 0x1004 containing 0xDEADBEEF, port 1 idle:
  - `mem_memread` high for exactly one cycle at t+1.
  - `r0_ack` at t+5 with `r0_rdata`=0xDEADBEEF; no `r1_ack`.
- Both ports request in the same cycle out of reset, both held continuously:
  - Port 0 is acked first, then port 1, then port 0.
  - Acks are 6 cycles apart.
- Port 1 stores 0x000000A5 to 0x2000, sign_mask 4'b0100:
  - `mem_memwrite`=1 and `mem_write_data`=0xA5 for one cycle.
  - `r1_ack` at t+5 and `rN_rdata` unchanged.
- Memory model never raises `mem_clk_stall`, `TIMEOUT_CYCLES`=15:
  - `r0_ack` and `r0_err` pulse at t+18 with `r0_rdata`=0.
  - `bus_err` stays 1 until `reset`.
- `reset` pulsed during WAIT_DONE while the memory model is still stalling, then `r0_req` applied immediately:
  - No ack for the aborted transaction.
  - No strobe issued until `mem_clk_stall`=0.
  - The new request completes normally.
